instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the instruction decoder and drives its INSTR input.
- Holds the PC and issues sequential word fetches to instruction memory over a valid/ready request and in-order response interface.
- Buffers returned words in a small queue and presents them downstream with a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the queue and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 4, instruction queue depth; also the cap on outstanding requests plus queued entries; power of two, ≥2.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IMEM_REQ_VALID  output  1  fetch request valid.
- IMEM_REQ_READY  input  1  memory accepts request.
- IMEM_ADDR  output  32  fetch address; always the current PC, low 2 bits zero.
- IMEM_RSP_VALID  input  1  response valid; in order, ≥1 cycle after acceptance, one per accepted request.
- IMEM_RSP_DATA  input  32  instruction word.
- REDIRECT_VALID  input  1  redirect PC (from branch/jump resolution).
- REDIRECT_PC  input  32  new PC; bits [1:0] ignored and treated as 0.
- INSTR_VALID  output  1  INSTR/INSTR_PC valid.
- INSTR_READY  input  1  decoder consumes the head entry.
- INSTR  output  32  instruction word to the decoder.
- INSTR_PC  output  32  PC of INSTR.

Behaviour:
- Reset (RST_N low, async):
  - PC=RESET_PC; queue empty; outstanding count OUT=0; drop count DROP=0.
  - INSTR_VALID=0, INSTR=0, INSTR_PC=0.
  - IMEM_REQ_VALID is forced 0 while RST_N is low.
- Reset mid-operation: all state is cleared immediately. Responses arriving after release are treated as protocol violations and ignored, because OUT=0.
- Credit rule: POP = INSTR_VALID & INSTR_READY.
  - IMEM_REQ_VALID = !REDIRECT_VALID & (OUT + OCC − POP < QDEPTH), where OCC is queue occupancy.
  - The queue can never overflow.
- Request accepted (VALID & READY): OUT+1 and PC+4 at the next edge. PC wraps from 32'hFFFF_FFFC to 0.
- Response (IMEM_RSP_VALID with OUT>0):
  - OUT−1.
  - If DROP>0: DROP−1 and the data is discarded.
  - Otherwise {data, fetch PC} is written to the queue tail.
  - The fetch PC comes from an internal PC-tag FIFO of depth QDEPTH that tracks in-flight request addresses.
- Latency: request accepted at cycle N, response at N+k, INSTR_VALID at N+k+1. Response to output is one registered stage with no bypass.
- Throughput: with QDEPTH=4 and memory latency ≤2, one instruction per cycle is sustained while INSTR_READY=1.
- Downstream handshake:
  - INSTR/INSTR_PC hold the queue head and stay stable while INSTR_VALID & !INSTR_READY.
  - When the queue is empty, INSTR=0 and INSTR_PC=0.
- Redirect (REDIRECT_VALID=1 at an edge):
  - PC ← {REDIRECT_PC[31:2],2'b00}.
  - Queue flushed.
  - DROP ← OUT + (1 if a response arrives this same cycle ? −1 : 0), i.e. every in-flight response is discarded.
  - No request is issued in the redirect cycle; the first request to the new PC is issued the next cycle.
- Simultaneous redirect and POP: the handshake completes from the decoder's view, and the queue is still fully flushed.
- Simultaneous redirect and response: that response is discarded.
- Back-to-back redirects: the last one wins; DROP is recomputed each time.
- Full queue with INSTR_READY=0: no new requests; existing responses still land because they are covered by credit.
- Counter widths: OUT, DROP and OCC are $clog2(QDEPTH+1) bits.

Decomposition:
- Package riscv_pkg:
  - XLEN=32, ILEN=32.
  - Default RESET_PC.
  - Localparam for the word increment (4).
- Sub-module fetch_queue: synchronous FIFO of {instr, pc}, depth QDEPTH, with synchronous flush input and occupancy output.
  - Instantiated once for the instruction queue.
  - Reused (pc-only width) for the PC-tag FIFO.

Test Plan:
- Reset release, memory latency 1, READY always 1:
  - IMEM_ADDR sequence 0,4,8,12 on consecutive cycles.
  - INSTR_VALID first rises 2 cycles after the first acceptance, then stays high.
  - INSTR_PC = 0,4,8.
- INSTR_READY=0 held 10 cycles, latency 1:
  - Exactly 4 requests issued, OCC=4, IMEM_REQ_VALID=0.
  - Head INSTR/INSTR_PC stay stable.
  - On READY=1, all 4 drain in order and fetching resumes.
- Redirect to 32'h0000_0103 with 2 responses in flight (latency 3):
  - Both old responses discarded, queue emptied.
  - Next IMEM_ADDR = 32'h0000_0100.
  - First INSTR_PC after redirect = 32'h100.
- Redirect in the same cycle as POP and as an arriving response:
  - No stale instruction appears on INSTR.
  - DROP counts correctly, checked by verifying the next output PC = redirect target.
- Redirect to 32'hFFFF_FFF8:
  - Fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - INSTR_PC wraps correspondingly.
- RST_N asserted mid-stream with 3 requests outstanding:
  - All outputs 0 immediately.
  - After release, fetching restarts at RESET_PC and stray responses are ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths, reset defaults and the fetch queue entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_INCR        = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with a synchronous flush and an occupancy count.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited memory requests, response queue
// towards the decoder, and redirect handling with in-flight response dropping.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              IMEM_REQ_VALID,
    input  logic              IMEM_REQ_READY,
    output logic [XLEN-1:0]   IMEM_ADDR,
    input  logic              IMEM_RSP_VALID,
    input  logic [ILEN-1:0]   IMEM_RSP_DATA,
    input  logic              REDIRECT_VALID,
    input  logic [XLEN-1:0]   REDIRECT_PC,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [ILEN-1:0]   INSTR,
    output logic [XLEN-1:0]   INSTR_PC
);

    localparam int unsigned   CW  = $clog2(QDEPTH+1);
    localparam logic [CW:0]   CAP = (CW+1)'(QDEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occ;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] tag_pc;
    fetch_entry_t    q_in;
    fetch_entry_t    q_head;
    logic            instr_valid;
    logic            pop;
    logic            req_fire;
    logic            rsp_fire;
    logic            q_push;

    assign instr_valid = (occ != '0);
    assign pop         = instr_valid & INSTR_READY;

    assign credit_used    = {1'b0, out_cnt} + {1'b0, occ} - {{CW{1'b0}}, pop};
    assign IMEM_REQ_VALID = RST_N & ~REDIRECT_VALID & (credit_used < CAP);
    assign IMEM_ADDR      = pc;

    assign req_fire = IMEM_REQ_VALID & IMEM_REQ_READY;
    assign rsp_fire = IMEM_RSP_VALID & (out_cnt != '0);
    assign q_push   = rsp_fire & (drop_cnt == '0) & ~REDIRECT_VALID;
    assign q_in     = '{instr: IMEM_RSP_DATA, pc: tag_pc};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc       <= RESET_PC & ALIGN_MASK;
            drop_cnt <= '0;
        end else if (REDIRECT_VALID) begin
            pc       <= REDIRECT_PC & ALIGN_MASK;
            drop_cnt <= out_cnt - CW'(rsp_fire);
        end else begin
            if (req_fire) pc <= pc + WORD_INCR;
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // The PC-tag FIFO holds exactly one entry per outstanding request, so its
    // occupancy doubles as the outstanding-request counter.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_tag_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_fire),
        .head      (tag_pc),
        .count     (out_cnt)
    );

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_instr_queue (
        .clk       (CLK),
        .rst_n     (RST_N),
        .flush     (REDIRECT_VALID),
        .push      (q_push),
        .push_data (q_in),
        .pop       (pop),
        .head      (q_head),
        .count     (occ)
    );

    assign INSTR_VALID = instr_valid;
    assign INSTR       = instr_valid ? q_head.instr : '0;
    assign INSTR_PC    = instr_valid ? q_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order, fixed-latency memory model.
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RSP_VALID = 1'b0;
    logic [31:0] IMEM_RSP_DATA  = '0;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;

    int n_vec  = 0;
    int n_miss = 0;

    int          lat      = 1;
    int          mcyc     = 0;
    int          last_due = 0;
    int          n_acc    = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (4)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .IMEM_REQ_VALID (IMEM_REQ_VALID),
        .IMEM_REQ_READY (IMEM_REQ_READY),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_RSP_VALID (IMEM_RSP_VALID),
        .IMEM_RSP_DATA  (IMEM_RSP_DATA),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .INSTR_VALID    (INSTR_VALID),
        .INSTR_READY    (INSTR_READY),
        .INSTR          (INSTR),
        .INSTR_PC       (INSTR_PC)
    );

    always #5 CLK = ~CLK;

    // Memory: returns ~addr as the instruction word, lat cycles after acceptance.
    always @(negedge CLK) begin
        int due;
        mcyc++;
        if (pend_due.size() > 0 && pend_due[0] == mcyc) begin
            IMEM_RSP_VALID = 1'b1;
            IMEM_RSP_DATA  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            IMEM_RSP_VALID = 1'b0;
            IMEM_RSP_DATA  = '0;
        end
        if (IMEM_REQ_VALID && IMEM_REQ_READY) begin
            due = mcyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(IMEM_ADDR);
            pend_due.push_back(due);
            n_acc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe();
        #3;
    endtask

    task automatic quiesce(input logic [31:0] tgt);
        IMEM_REQ_READY = 1'b0;
        repeat (4) cycle();
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = tgt;
        cycle();
        REDIRECT_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        RST_N          = 1'b0;
        IMEM_REQ_READY = 1'b1;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = '0;
        INSTR_READY    = 1'b1;

        // Reset state
        cycle(); probe();
        chk("rst_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
        chk("rst_instr_valid", 32'(INSTR_VALID), 32'd0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_instr_pc", INSTR_PC, 32'h0);
        chk("rst_addr", IMEM_ADDR, 32'h0);

        // Release, latency 1, decoder always ready
        cycle(); RST_N = 1'b1; probe();
        chk("t1_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
        chk("t1_addr0", IMEM_ADDR, 32'h0);
        chk("t1_iv0", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t1_addr1", IMEM_ADDR, 32'h4);
        chk("t1_iv1", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t1_addr2", IMEM_ADDR, 32'h8);
        chk("t1_iv2", 32'(INSTR_VALID), 32'd1);
        chk("t1_pc2", INSTR_PC, 32'h0);
        chk("t1_instr2", INSTR, 32'hFFFF_FFFF);
        cycle(); probe();
        chk("t1_addr3", IMEM_ADDR, 32'hC);
        chk("t1_pc3", INSTR_PC, 32'h4);
        cycle(); probe();
        chk("t1_iv4", 32'(INSTR_VALID), 32'd1);
        chk("t1_pc4", INSTR_PC, 32'h8);

        // Decoder stalled for 10 cycles: queue fills to depth, requests stop
        quiesce(32'h20);
        INSTR_READY    = 1'b0;
        IMEM_REQ_READY = 1'b1;
        acc0           = n_acc;
        probe();
        chk("t2_addr0", IMEM_ADDR, 32'h20);
        cycle(); probe();
        chk("t2_addr1", IMEM_ADDR, 32'h24);
        cycle(); probe();
        chk("t2_addr2", IMEM_ADDR, 32'h28);
        chk("t2_pc2", INSTR_PC, 32'h20);
        cycle(); probe();
        chk("t2_addr3", IMEM_ADDR, 32'h2C);
        chk("t2_req3", 32'(IMEM_REQ_VALID), 32'd1);
        for (int i = 4; i < 10; i++) begin
            cycle(); probe();
            chk("t2_hold_req", 32'(IMEM_REQ_VALID), 32'd0);
            chk("t2_hold_pc", INSTR_PC, 32'h20);
            chk("t2_hold_instr", INSTR, 32'hFFFF_FFDF);
        end
        chk("t2_req_count", 32'(n_acc - acc0), 32'd4);
        cycle(); INSTR_READY = 1'b1; probe();
        chk("t2_resume_req", 32'(IMEM_REQ_VALID), 32'd1);
        chk("t2_resume_addr", IMEM_ADDR, 32'h30);
        chk("t2_drain_pc0", INSTR_PC, 32'h20);
        for (int i = 1; i < 6; i++) begin
            cycle(); probe();
            chk("t2_drain_pc", INSTR_PC, 32'h20 + 32'(4 * i));
            chk("t2_drain_iv", 32'(INSTR_VALID), 32'd1);
        end

        // Redirect to unaligned target with two responses in flight, latency 3
        quiesce(32'h40);
        lat            = 3;
        IMEM_REQ_READY = 1'b1;
        probe();
        chk("t3_addr0", IMEM_ADDR, 32'h40);
        cycle(); probe();
        chk("t3_addr1", IMEM_ADDR, 32'h44);
        cycle(); REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h0000_0103; probe();
        chk("t3_redir_req", 32'(IMEM_REQ_VALID), 32'd0);
        cycle(); REDIRECT_VALID = 1'b0; probe();
        chk("t3_new_req", 32'(IMEM_REQ_VALID), 32'd1);
        chk("t3_new_addr", IMEM_ADDR, 32'h100);
        chk("t3_iv_a3", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t3_addr_a4", IMEM_ADDR, 32'h104);
        chk("t3_iv_a4", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t3_iv_a5", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t3_iv_a6", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t3_iv_a7", 32'(INSTR_VALID), 32'd1);
        chk("t3_pc_a7", INSTR_PC, 32'h100);
        chk("t3_instr_a7", INSTR, 32'hFFFF_FEFF);
        cycle(); probe();
        chk("t3_pc_a8", INSTR_PC, 32'h104);
        cycle(); probe();
        chk("t3_pc_a9", INSTR_PC, 32'h108);

        // Redirect coinciding with a POP and an arriving response, latency 2
        quiesce(32'h80);
        lat            = 2;
        IMEM_REQ_READY = 1'b1;
        probe();
        chk("t4_addr0", IMEM_ADDR, 32'h80);
        cycle(); probe();
        chk("t4_addr1", IMEM_ADDR, 32'h84);
        cycle(); probe();
        chk("t4_iv2", 32'(INSTR_VALID), 32'd0);
        cycle(); REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h300; probe();
        chk("t4_pop_iv", 32'(INSTR_VALID), 32'd1);
        chk("t4_pop_pc", INSTR_PC, 32'h80);
        chk("t4_redir_req", 32'(IMEM_REQ_VALID), 32'd0);
        cycle(); REDIRECT_VALID = 1'b0; probe();
        chk("t4_no_stale_b4", 32'(INSTR_VALID), 32'd0);
        chk("t4_addr_b4", IMEM_ADDR, 32'h300);
        cycle(); probe();
        chk("t4_no_stale_b5", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t4_no_stale_b6", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t4_iv_b7", 32'(INSTR_VALID), 32'd1);
        chk("t4_pc_b7", INSTR_PC, 32'h300);
        cycle(); probe();
        chk("t4_pc_b8", INSTR_PC, 32'h304);

        // PC wrap at the top of the address space, latency 1
        quiesce(32'hFFFF_FFF8);
        lat            = 1;
        IMEM_REQ_READY = 1'b1;
        probe();
        chk("t5_addr0", IMEM_ADDR, 32'hFFFF_FFF8);
        cycle(); probe();
        chk("t5_addr1", IMEM_ADDR, 32'hFFFF_FFFC);
        cycle(); probe();
        chk("t5_addr2", IMEM_ADDR, 32'h0);
        chk("t5_pc2", INSTR_PC, 32'hFFFF_FFF8);
        chk("t5_instr2", INSTR, 32'h0000_0007);
        cycle(); probe();
        chk("t5_pc3", INSTR_PC, 32'hFFFF_FFFC);
        cycle(); probe();
        chk("t5_pc4", INSTR_PC, 32'h0);

        // Reset mid-stream with three requests outstanding, latency 3
        quiesce(32'h500);
        lat            = 3;
        IMEM_REQ_READY = 1'b1;
        probe();
        chk("t6_addr0", IMEM_ADDR, 32'h500);
        cycle(); probe();
        cycle(); probe();
        chk("t6_addr2", IMEM_ADDR, 32'h508);
        cycle(); RST_N = 1'b0; probe();
        chk("t6_rst_req", 32'(IMEM_REQ_VALID), 32'd0);
        chk("t6_rst_iv", 32'(INSTR_VALID), 32'd0);
        chk("t6_rst_instr", INSTR, 32'h0);
        chk("t6_rst_pc", INSTR_PC, 32'h0);
        chk("t6_rst_addr", IMEM_ADDR, 32'h0);
        cycle(); RST_N = 1'b1; IMEM_REQ_READY = 1'b0; probe();
        chk("t6_rel_iv", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t6_stray_iv", 32'(INSTR_VALID), 32'd0);
        chk("t6_stray_req", 32'(IMEM_REQ_VALID), 32'd1);
        cycle(); IMEM_REQ_READY = 1'b1; probe();
        chk("t6_restart_addr", IMEM_ADDR, 32'h0);
        chk("t6_restart_req", 32'(IMEM_REQ_VALID), 32'd1);
        cycle(); probe();
        chk("t6_addr_d7", IMEM_ADDR, 32'h4);
        cycle(); probe();
        cycle(); probe();
        chk("t6_iv_d9", 32'(INSTR_VALID), 32'd0);
        cycle(); probe();
        chk("t6_iv_d10", 32'(INSTR_VALID), 32'd1);
        chk("t6_pc_d10", INSTR_PC, 32'h0);
        chk("t6_instr_d10", INSTR, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
